// File: rtl/checkpoint_recovery_ctrl_if.sv
// Recovery controller bus: exbru request/ack, commit flush, checkpoint buffer
// read/rollback/flush, RAT restore bus, fetch stall and perf counters.
// master = recovery controller side, slave = surrounding pipeline.
`ifndef CHECKPOINT_ID_WIDTH
`define CHECKPOINT_ID_WIDTH 3
`endif

interface checkpoint_recovery_ctrl_if #(
    parameter int ID_W   = `CHECKPOINT_ID_WIDTH,
    parameter int DATA_W = 16
);
    logic              exbru_recov_req;
    logic [ID_W-1:0]   exbru_recov_id;
    logic              recov_exbru_ack;
    logic              commit_recov_flush;
    logic [ID_W-1:0]   recov_cpbuf_id;
    logic [DATA_W-1:0] cpbuf_recov_data;
    logic              recov_rat_restore;
    logic [DATA_W-1:0] recov_rat_data;
    logic              recov_cpbuf_rollback;
    logic [ID_W-1:0]   recov_cpbuf_rollback_id;
    logic              recov_cpbuf_flush;
    logic              recov_fetch_stall;
    logic [31:0]       recov_perf_recover_cnt;
    logic [31:0]       recov_perf_abort_cnt;

    modport master (
        input  exbru_recov_req, exbru_recov_id, commit_recov_flush, cpbuf_recov_data,
        output recov_exbru_ack, recov_cpbuf_id, recov_rat_restore, recov_rat_data,
               recov_cpbuf_rollback, recov_cpbuf_rollback_id, recov_cpbuf_flush,
               recov_fetch_stall, recov_perf_recover_cnt, recov_perf_abort_cnt
    );

    modport slave (
        output exbru_recov_req, exbru_recov_id, commit_recov_flush, cpbuf_recov_data,
        input  recov_exbru_ack, recov_cpbuf_id, recov_rat_restore, recov_rat_data,
               recov_cpbuf_rollback, recov_cpbuf_rollback_id, recov_cpbuf_flush,
               recov_fetch_stall, recov_perf_recover_cnt, recov_perf_abort_cnt
    );
endinterface

// File: rtl/checkpoint_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: IDLE -> READ -> RESTORE (held for
// RESTORE_CYCLES) -> ROLLBACK pulse -> IDLE. A commit flush wins in IDLE and
// aborts any recovery in flight, producing a one-cycle buffer flush pulse.
// Optional feature macro: CHECKPOINT_RECOVERY_PERF_EN (saturating perf counters).
`ifndef CHECKPOINT_ID_WIDTH
`define CHECKPOINT_ID_WIDTH 3
`endif
`ifndef CHECKPOINT_BUFFER_SIZE
`define CHECKPOINT_BUFFER_SIZE 6
`endif

module checkpoint_recovery_ctrl #(
    parameter int CHECKPOINT_ID_WIDTH    = `CHECKPOINT_ID_WIDTH,
    parameter int CHECKPOINT_BUFFER_SIZE = `CHECKPOINT_BUFFER_SIZE,
    parameter int RESTORE_CYCLES         = 2,
    parameter int CHECKPOINT_DATA_WIDTH  = 16
) (
    input logic clk,
    input logic rst,
    checkpoint_recovery_ctrl_if.master bus
);
    localparam int IDW   = CHECKPOINT_ID_WIDTH;
    localparam int DW    = CHECKPOINT_DATA_WIDTH;
    localparam int CNT_W = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RESTORE,
        S_ROLLBACK,
        S_FLUSH
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rb_id_q;
    logic [DW-1:0]    data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             restore_q;
    logic             rollback_q;
    logic             flush_q;
    logic             stall_q;

    // Successor id with explicit wrap so non-power-of-2 buffers work.
    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        if (id == IDW'(CHECKPOINT_BUFFER_SIZE - 1)) begin
            return '0;
        end
        return id + IDW'(1);
    endfunction

    // Ack is combinational in IDLE; flush has priority over a request.
    assign bus.recov_exbru_ack = rst && (state_q == S_IDLE) &&
                                 bus.exbru_recov_req && !bus.commit_recov_flush;

    assign bus.recov_cpbuf_id          = id_q;
    assign bus.recov_cpbuf_rollback_id = rb_id_q;
    assign bus.recov_rat_data          = data_q;
    assign bus.recov_rat_restore       = restore_q;
    assign bus.recov_cpbuf_rollback    = rollback_q;
    assign bus.recov_cpbuf_flush       = flush_q;
    assign bus.recov_fetch_stall       = stall_q;

    // Recovery FSM with registered outputs; an abort drops restore/rollback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            rb_id_q    <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            restore_q  <= 1'b0;
            rollback_q <= 1'b0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.commit_recov_flush) begin
                        state_q <= S_FLUSH;
                        flush_q <= 1'b1;
                        stall_q <= 1'b1;
                    end else if (bus.exbru_recov_req) begin
                        state_q <= S_READ;
                        id_q    <= bus.exbru_recov_id;
                        rb_id_q <= next_id(bus.exbru_recov_id);
                        stall_q <= 1'b1;
                    end
                end
                S_READ, S_RESTORE, S_ROLLBACK: begin
                    if (bus.commit_recov_flush) begin
                        state_q    <= S_FLUSH;
                        restore_q  <= 1'b0;
                        rollback_q <= 1'b0;
                        flush_q    <= 1'b1;
                        stall_q    <= 1'b1;
                    end else if (state_q == S_READ) begin
                        data_q    <= bus.cpbuf_recov_data;
                        restore_q <= 1'b1;
                        cnt_q     <= CNT_W'(RESTORE_CYCLES - 1);
                        state_q   <= S_RESTORE;
                    end else if (state_q == S_RESTORE) begin
                        if (cnt_q == '0) begin
                            restore_q  <= 1'b0;
                            rollback_q <= 1'b1;
                            state_q    <= S_ROLLBACK;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end else begin
                        rollback_q <= 1'b0;
                        stall_q    <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    flush_q <= 1'b0;
                    stall_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    restore_q  <= 1'b0;
                    rollback_q <= 1'b0;
                    flush_q    <= 1'b0;
                    stall_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef CHECKPOINT_RECOVERY_PERF_EN
    logic [31:0] recover_cnt_q;
    logic [31:0] abort_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count completed rollbacks and flush-aborted recoveries, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recover_cnt_q <= '0;
            abort_cnt_q   <= '0;
        end else begin
            if (state_q == S_ROLLBACK) begin
                recover_cnt_q <= sat_inc(recover_cnt_q);
            end
            if (bus.commit_recov_flush && (state_q == S_READ || state_q == S_RESTORE ||
                                           state_q == S_ROLLBACK)) begin
                abort_cnt_q <= sat_inc(abort_cnt_q);
            end
        end
    end

    assign bus.recov_perf_recover_cnt = recover_cnt_q;
    assign bus.recov_perf_abort_cnt   = abort_cnt_q;
`else
    assign bus.recov_perf_recover_cnt = '0;
    assign bus.recov_perf_abort_cnt   = '0;
`endif

endmodule

// File: tb/tb_checkpoint_recovery_ctrl.sv
// Bench for checkpoint_recovery_ctrl: directed scenarios plus random traffic,
// checked every cycle against a timeline model (cycles since ack).
module tb_checkpoint_recovery_ctrl;
    localparam int IDW  = 3;
    localparam int SIZE = 6;
    localparam int R    = 2;
    localparam int DW   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    checkpoint_recovery_ctrl_if #(.ID_W(IDW), .DATA_W(DW)) bus ();

    checkpoint_recovery_ctrl #(
        .CHECKPOINT_ID_WIDTH(IDW), .CHECKPOINT_BUFFER_SIZE(SIZE),
        .RESTORE_CYCLES(R), .CHECKPOINT_DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Checkpoint buffer contents, read combinationally by the DUT.
    logic [DW-1:0] mem [SIZE];
    assign bus.cpbuf_recov_data = (int'(bus.recov_cpbuf_id) < SIZE) ? mem[bus.recov_cpbuf_id] : '0;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode 0 idle, 1 recovery in progress (m_k cycles since ack), 2 flush pulse.
    int            m_mode, m_k, m_lid;
    logic [DW-1:0] m_data;
    longint        m_rec, m_abt;

    // Observed values of the last cycle.
    logic          o_ack, o_restore, o_rb, o_flush, o_stall;
    logic [IDW-1:0] o_cpid, o_rbid;
    logic [DW-1:0] o_data;
    logic [31:0]   o_prec, o_pabt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_lid = 0; m_data = '0; m_rec = 0; m_abt = 0;
    endtask

    task automatic capture();
        o_ack = bus.recov_exbru_ack;       o_restore = bus.recov_rat_restore;
        o_rb = bus.recov_cpbuf_rollback;   o_flush = bus.recov_cpbuf_flush;
        o_stall = bus.recov_fetch_stall;   o_cpid = bus.recov_cpbuf_id;
        o_rbid = bus.recov_cpbuf_rollback_id; o_data = bus.recov_rat_data;
        o_prec = bus.recov_perf_recover_cnt;  o_pabt = bus.recov_perf_abort_cnt;
    endtask

    task automatic check_all(input logic r, input logic f);
        logic e_rb;
        e_rb = (m_mode == 1) && (m_k == 2 + R);
        chk("ack", o_ack, (m_mode == 0) && r && !f);
        chk("restore", o_restore, (m_mode == 1) && m_k >= 2 && m_k <= 1 + R);
        chk("rollback", o_rb, e_rb);
        chk("flush", o_flush, m_mode == 2);
        chk("stall", o_stall, m_mode != 0);
        chk("cpbuf_id", o_cpid, m_lid);
        chk("rat_data", o_data, m_data);
        if (e_rb) chk("rollback_id", o_rbid, (m_lid + 1) % SIZE);
`ifdef CHECKPOINT_RECOVERY_PERF_EN
        chk("perf_rec", o_prec, m_rec);
        chk("perf_abt", o_pabt, m_abt);
`else
        chk("perf_rec", o_prec, 0);
        chk("perf_abt", o_pabt, 0);
`endif
    endtask

    task automatic model_step(input logic r, input int id, input logic f);
        case (m_mode)
            0: begin
                if (f) m_mode = 2;
                else if (r) begin m_mode = 1; m_k = 1; m_lid = id; end
            end
            2: m_mode = 0;
            default: begin
                if (m_k == 2 + R) m_rec++;
                if (f) begin m_abt++; m_mode = 2; end
                else if (m_k == 1) begin m_data = mem[m_lid]; m_k++; end
                else if (m_k == 2 + R) m_mode = 0;
                else m_k++;
            end
        endcase
    endtask

    task automatic cycle(input logic r, input int id, input logic f);
        @(negedge clk);
        bus.exbru_recov_req = r;
        bus.exbru_recov_id = IDW'(id);
        bus.commit_recov_flush = f;
        #1;
        capture();
        check_all(r, f);
        @(posedge clk);
        model_step(r, id, f);
    endtask

    task automatic check_zero(input string tag);
        capture();
        chk({tag, "_ack"}, o_ack, 0);       chk({tag, "_restore"}, o_restore, 0);
        chk({tag, "_rollback"}, o_rb, 0);   chk({tag, "_flush"}, o_flush, 0);
        chk({tag, "_stall"}, o_stall, 0);   chk({tag, "_cpid"}, o_cpid, 0);
        chk({tag, "_rbid"}, o_rbid, 0);     chk({tag, "_data"}, o_data, 0);
        chk({tag, "_prec"}, o_prec, 0);     chk({tag, "_pabt"}, o_pabt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.exbru_recov_req = 1'b0;
        bus.commit_recov_flush = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero("rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.exbru_recov_req = 1'b0;
        bus.exbru_recov_id = '0;
        bus.commit_recov_flush = 1'b0;
        for (int i = 0; i < SIZE; i++) mem[i] = DW'(16'h100 + i);
        mem[1] = 16'd3;
        rst = 1'b0;
        model_reset();
        #1 check_zero("init");
        @(negedge clk);
        rst = 1'b1;

        // Test 1: reset asserted mid-RESTORE clears outputs at once.
        cycle(1, 2, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("t1_in_restore", o_restore, 1);
        do_reset();
        cycle(0, 0, 0);
        chk("t1_idle_stall", o_stall, 0);

        // Test 2: id=1, checkpoint value 3, full timeline.
        cycle(1, 1, 0); chk("t2_ack_c0", o_ack, 1);
        cycle(0, 0, 0); chk("t2_cpid_c1", o_cpid, 1);
        cycle(0, 0, 0); chk("t2_restore_c2", o_restore, 1); chk("t2_data_c2", o_data, 3);
        cycle(0, 0, 0); chk("t2_restore_c3", o_restore, 1);
        cycle(0, 0, 0); chk("t2_rb_c4", o_rb, 1); chk("t2_rbid_c4", o_rbid, 2);
        cycle(0, 0, 0); chk("t2_stall_c5", o_stall, 0);

        // Test 3: wrap of rollback id.
        cycle(1, SIZE - 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        cycle(0, 0, 0); chk("t3_rb", o_rb, 1); chk("t3_rbid_wrap", o_rbid, 0);
        cycle(0, 0, 0);

        // Test 4: flush during RESTORE aborts with no rollback.
        do_reset();
        cycle(1, 2, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1); chk("t4_restore_c2", o_restore, 1);
        cycle(0, 0, 0); chk("t4_restore_c3", o_restore, 0); chk("t4_flush_c3", o_flush, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0); chk("t4_no_rb", o_rb, 0);
        end
`ifdef CHECKPOINT_RECOVERY_PERF_EN
        chk("t4_abort_cnt", o_pabt, 1);
`endif

        // Test 5: request and flush in the same IDLE cycle.
        cycle(1, 3, 1); chk("t5_ack_c0", o_ack, 0);
        cycle(1, 3, 0); chk("t5_flush_c1", o_flush, 1); chk("t5_ack_c1", o_ack, 0);
        cycle(1, 3, 0); chk("t5_ack_c2", o_ack, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);

        // Test 6: request held high across two ids.
        do_reset();
        cycle(1, 1, 0); chk("t6_ack1", o_ack, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 4, 0); chk("t6_noack", o_ack, 0);
        end
        cycle(1, 4, 0); chk("t6_ack2_c5", o_ack, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        cycle(0, 0, 0);
`ifdef CHECKPOINT_RECOVERY_PERF_EN
        chk("t6_recover_cnt", o_prec, 2);
`else
        chk("t6_recover_cnt", o_prec, 0);
`endif

        // Random traffic: requests held until acked, occasional flushes.
        for (int i = 0; i < SIZE; i++) mem[i] = DW'($urandom);
        begin
            logic pend;
            int   pid;
            logic fl;
            pend = 1'b0;
            pid = 0;
            for (int c = 0; c < 400; c++) begin
                if (!pend && ($urandom % 3 == 0)) begin
                    pend = 1'b1;
                    pid = int'($urandom_range(0, SIZE - 1));
                end
                fl = ($urandom % 12 == 0);
                if (m_mode == 0 && pend && !fl) begin
                    cycle(pend, pid, fl);
                    pend = 1'b0;
                end else begin
                    cycle(pend, pid, fl);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
